uart_status_tx: RTL and testbench

//  UART transmit path back to the terminal: the outbound counterpart of the controller's rx_data/rx_done receive link.

---
 rtl/uart_status_tx_pkg.sv | 32 +++
 rtl/uart_tx_byte.sv | 98 +++++++++
 rtl/uart_status_tx.sv | 140 ++++++++++++++
 tb/tb_uart_status_tx.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_status_tx_pkg.sv
// Shared constants for the status-line UART transmitter: ASCII bytes of the line,
// default bit timing and the FSM state encodings of the message and byte engines.
package uart_status_tx_pkg;

    localparam int DEF_CLKS_PER_BIT = 5208;

    localparam logic [7:0] TAG_M   = 8'h4D;
    localparam logic [7:0] TAG_A   = 8'h41;
    localparam logic [7:0] TAG_D   = 8'h44;
    localparam logic [7:0] COLON   = 8'h3A;
    localparam logic [7:0] SPACE   = 8'h20;
    localparam logic [7:0] CR      = 8'h0D;
    localparam logic [7:0] LF      = 8'h0A;
    localparam logic [7:0] ASCII_0 = 8'h30;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [1:0] T_IDLE  = 2'd0;
    localparam logic [1:0] T_START = 2'd1;
    localparam logic [1:0] T_DATA  = 2'd2;
    localparam logic [1:0] T_STOP  = 2'd3;

    // Uppercase hex digit in ASCII.
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'b0000, n}) : (8'h37 + {4'b0000, n});
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer: one start bit, eight data bits LSB first, one stop bit,
// each held for CLKS_PER_BIT clocks; byte_done marks the last stop-bit cycle.
module uart_tx_byte
    import uart_status_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       byte_start,
    input  logic [7:0] byte_data,
    output logic       tx,
    output logic       byte_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        unique case (state_q)
            T_IDLE: begin
                tx_d = 1'b1;
                if (byte_start) begin
                    state_d = T_START;
                    cnt_d   = '0;
                    shift_d = byte_data;
                    tx_d    = 1'b0;
                end
            end
            T_START: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d   = T_DATA;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end
            end
            T_DATA: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = T_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            T_STOP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d = T_IDLE;
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                end
            end
            default: begin
                state_d = T_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= T_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    assign tx        = tx_q;
    assign byte_done = (state_q == T_STOP) && (cnt_q == LAST);

endmodule

// File: rtl/uart_status_tx.sv
// Sends one 8-byte ASCII status line ("T:HH H\r\n") per controller day-cycle event
// over 8N1 UART; events are queued as pending flags and served D > A > M.
module uart_status_tx
    import uart_status_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       morning_signal,
    input  logic       after_signal,
    input  logic       day_done,
    input  logic       heat_signal,
    input  logic [7:0] led_level,
    output logic       tx,
    output logic       busy,
    output logic       msg_done
);

    logic       morning_q, morning_d;
    logic       after_q, after_d;
    logic       pend_m_q, pend_m_d;
    logic       pend_a_q, pend_a_d;
    logic       pend_d_q, pend_d_d;
    logic [2:0] state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] tag_q, tag_d;
    logic [7:0] led_q, led_d;
    logic       heat_q, heat_d;

    logic       byte_start;
    logic       byte_done;
    logic [7:0] byte_data;

    always_comb begin
        morning_d  = morning_signal;
        after_d    = after_signal;
        // Set before clear, so a same-tag event in the take cycle is absorbed.
        pend_m_d   = pend_m_q | (morning_signal & ~morning_q);
        pend_a_d   = pend_a_q | (after_signal & ~after_q);
        pend_d_d   = pend_d_q | day_done;
        state_d    = state_q;
        idx_d      = idx_q;
        tag_d      = tag_q;
        led_d      = led_q;
        heat_d     = heat_q;
        byte_start = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (pend_m_q || pend_a_q || pend_d_q) state_d = S_START;
            end
            S_START: begin
                idx_d  = '0;
                led_d  = led_level;
                heat_d = heat_signal;
                if (pend_d_q) begin
                    tag_d    = TAG_D;
                    pend_d_d = 1'b0;
                end else if (pend_a_q) begin
                    tag_d    = TAG_A;
                    pend_a_d = 1'b0;
                end else begin
                    tag_d    = TAG_M;
                    pend_m_d = 1'b0;
                end
                state_d = S_LOAD;
            end
            S_LOAD: begin
                byte_start = 1'b1;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (byte_done) begin
                    if (idx_q == 3'd7) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_LOAD;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        unique case (idx_q)
            3'd0:    byte_data = tag_q;
            3'd1:    byte_data = COLON;
            3'd2:    byte_data = hex_ascii(led_q[7:4]);
            3'd3:    byte_data = hex_ascii(led_q[3:0]);
            3'd4:    byte_data = SPACE;
            3'd5:    byte_data = ASCII_0 | {7'b0000000, heat_q};
            3'd6:    byte_data = CR;
            default: byte_data = LF;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            morning_q <= 1'b0;
            after_q   <= 1'b0;
            pend_m_q  <= 1'b0;
            pend_a_q  <= 1'b0;
            pend_d_q  <= 1'b0;
            state_q   <= S_IDLE;
            idx_q     <= '0;
            tag_q     <= '0;
            led_q     <= '0;
            heat_q    <= 1'b0;
        end else begin
            morning_q <= morning_d;
            after_q   <= after_d;
            pend_m_q  <= pend_m_d;
            pend_a_q  <= pend_a_d;
            pend_d_q  <= pend_d_d;
            state_q   <= state_d;
            idx_q     <= idx_d;
            tag_q     <= tag_d;
            led_q     <= led_d;
            heat_q    <= heat_d;
        end
    end

    assign busy     = (state_q == S_START) || (state_q == S_LOAD) || (state_q == S_WAIT);
    assign msg_done = (state_q == S_DONE);

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_byte (
        .clk       (clk),
        .n_rst     (n_rst),
        .byte_start(byte_start),
        .byte_data (byte_data),
        .tx        (tx),
        .byte_done (byte_done)
    );

endmodule

// File: tb/tb_uart_status_tx.sv
// Bench for uart_status_tx: a UART monitor decodes tx into bytes, which are compared
// against status lines built from the event rules (fixed vectors, corner cases, random).
module tb_uart_status_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       morning_signal = 1'b0;
    logic       after_signal = 1'b0;
    logic       day_done = 1'b0;
    logic       heat_signal = 1'b0;
    logic [7:0] led_level = 8'h00;
    logic       tx, busy, msg_done;

    int checks = 0;
    int errors = 0;

    logic [7:0] rx_q[$];
    logic       mon_act = 1'b0;
    int         mon_cnt = 0;
    logic [7:0] mon_sh = 8'h00;
    int         frame_err = 0;

    typedef struct {
        logic [7:0]  led;
        logic        heat;
        logic [2:0]  ev;
        logic [63:0] exp;
    } vec_t;
    vec_t tbl[6];

    uart_status_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .morning_signal(morning_signal),
        .after_signal  (after_signal),
        .day_done      (day_done),
        .heat_signal   (heat_signal),
        .led_level     (led_level),
        .tx            (tx),
        .busy          (busy),
        .msg_done      (msg_done)
    );

    always #5 clk = ~clk;

    // Receiver: first low sample is start-bit cycle 0; sample each bit mid-way.
    always @(negedge clk) begin
        if (!n_rst) begin
            mon_act <= 1'b0;
            mon_cnt <= 0;
        end else if (!mon_act) begin
            if (tx == 1'b0) begin
                mon_act <= 1'b1;
                mon_cnt <= 1;
            end
        end else begin
            mon_cnt <= mon_cnt + 1;
            if ((mon_cnt % CPB) == CPB / 2) begin
                if (mon_cnt / CPB >= 1 && mon_cnt / CPB <= 8)
                    mon_sh[3'(mon_cnt / CPB - 1)] <= tx;
                else if (mon_cnt / CPB == 9) begin
                    mon_act <= 1'b0;
                    rx_q.push_back(mon_sh);
                    if (tx !== 1'b1) frame_err <= frame_err + 1;
                end
            end
        end
    end

    function automatic logic [7:0] tag_byte(input int t);
        string tags;
        tags = "MAD";
        return tags[t];
    endfunction

    function automatic logic [63:0] mk_line(input int t, input logic [7:0] led, input logic heat);
        string hx;
        hx = "0123456789ABCDEF";
        return {tag_byte(t), ":", hx[led[7:4]], hx[led[3:0]], " ", (heat ? "1" : "0"), 8'h0D, 8'h0A};
    endfunction

    function automatic logic [63:0] rx_line(input int base);
        logic [63:0] r;
        r = 'x;
        if (base + 8 <= rx_q.size())
            for (int j = 0; j < 8; j++) r[63 - 8 * j -: 8] = rx_q[base + j];
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fire(input logic [2:0] ev);
        @(negedge clk);
        morning_signal = ev[0];
        after_signal   = ev[1];
        day_done       = ev[2];
        @(negedge clk);
        morning_signal = 1'b0;
        after_signal   = 1'b0;
        day_done       = 1'b0;
    endtask

    task automatic run_count(input int cycles, output int got, output logic busy_last);
        got = 0;
        busy_last = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (msg_done) begin
                got++;
                busy_last = busy;
            end
        end
    endtask

    task automatic wait_bytes(input int n, output logic ok);
        ok = 1'b0;
        for (int c = 0; c < 400 && !ok; c++) begin
            @(negedge clk);
            if (rx_q.size() >= n) ok = 1'b1;
        end
    endtask

    initial begin
        int          base, got, sz, lows, n, first;
        logic        bl, ok;
        logic [2:0]  s, e, rem;
        logic [7:0]  led;
        logic        heat;
        logic [39:0] cap, expv;
        logic [63:0] lines[4];
        logic [7:0]  b4d;

        tbl[0] = '{8'hA5, 1'b1, 3'b001, 64'h4D3A4135_20310D0A};
        tbl[1] = '{8'h0F, 1'b0, 3'b100, 64'h443A3046_20300D0A};
        tbl[2] = '{8'h00, 1'b0, 3'b010, 64'h413A3030_20300D0A};
        tbl[3] = '{8'hFF, 1'b1, 3'b100, 64'h443A4646_20310D0A};
        tbl[4] = '{8'h9A, 1'b0, 3'b001, 64'h4D3A3941_20300D0A};
        tbl[5] = '{8'h3C, 1'b1, 3'b010, 64'h413A3343_20310D0A};

        repeat (3) @(negedge clk);
        chk("reset_outputs", {61'd0, tx, busy, msg_done}, 64'd4);
        n_rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_outputs", {61'd0, tx, busy, msg_done}, 64'd4);

        for (int i = 0; i < 6; i++) begin
            led_level   = tbl[i].led;
            heat_signal = tbl[i].heat;
            base = rx_q.size();
            fire(tbl[i].ev);
            run_count(500, got, bl);
            chk($sformatf("vec%0d_line", i), rx_line(base), tbl[i].exp);
            chk($sformatf("vec%0d_done", i), 64'(got), 64'd1);
            chk($sformatf("vec%0d_busy_at_done", i), {63'd0, bl}, 64'd0);
        end

        // Simultaneous morning rise and day_done.
        led_level = 8'h0F; heat_signal = 1'b0;
        base = rx_q.size();
        fire(3'b101);
        run_count(900, got, bl);
        chk("both_done", 64'(got), 64'd2);
        chk("both_bytes", 64'(rx_q.size() - base), 64'd16);
        chk("both_line0", rx_line(base), 64'h443A3046_20300D0A);
        chk("both_line1", rx_line(base + 8), 64'h4D3A3046_20300D0A);

        // After event arrives during byte 3; snapshot change must not leak.
        led_level = 8'h12; heat_signal = 1'b0;
        base = rx_q.size();
        fire(3'b001);
        wait_bytes(base + 2, ok);
        chk("mid_wait", {63'd0, ok}, 64'd1);
        repeat (5) @(negedge clk);
        led_level = 8'hEE; heat_signal = 1'b1;
        fire(3'b010);
        run_count(900, got, bl);
        chk("mid_done", 64'(got), 64'd2);
        chk("mid_line0", rx_line(base), mk_line(0, 8'h12, 1'b0));
        chk("mid_line1", rx_line(base + 8), 64'h413A4545_20310D0A);

        // Level held 100 bit-times, three day_done pulses while busy.
        led_level = 8'h5A; heat_signal = 1'b0;
        base = rx_q.size();
        got = 0;
        for (int c = 0; c < 1200; c++) begin
            @(negedge clk);
            if (msg_done) got++;
            morning_signal = (c < 100 * CPB);
            day_done = (c == 50 || c == 61 || c == 72);
        end
        chk("hold_done", 64'(got), 64'd2);
        chk("hold_bytes", 64'(rx_q.size() - base), 64'd16);
        chk("hold_line0", rx_line(base), mk_line(0, 8'h5A, 1'b0));
        chk("hold_line1", rx_line(base + 8), mk_line(2, 8'h5A, 1'b0));

        // Exact bit timing of the first byte 0x4D.
        b4d = 8'h4D;
        expv = '0;
        for (int k = 0; k < 8; k++)
            for (int p = 0; p < CPB; p++) expv[CPB * (k + 1) + p] = b4d[k];
        for (int p = 0; p < CPB; p++) expv[9 * CPB + p] = 1'b1;
        fire(3'b001);
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            if (tx == 1'b0) ok = 1'b1;
        end
        chk("timing_start_seen", {63'd0, ok}, 64'd1);
        cap = '0;
        cap[0] = tx;
        for (int c = 1; c < 10 * CPB; c++) begin
            @(negedge clk);
            cap[c] = tx;
        end
        chk("timing_frame", {24'd0, cap}, {24'd0, expv});
        run_count(500, got, bl);
        chk("timing_done", 64'(got), 64'd1);

        // Randomized event sets checked against the pending-set model.
        for (int it = 0; it < 8; it++) begin
            led  = 8'($urandom);
            heat = 1'($urandom_range(0, 1));
            s    = 3'($urandom_range(1, 7));
            led_level = led; heat_signal = heat;
            base = rx_q.size();
            fire(s);
            repeat (60) @(negedge clk);
            e = '0;
            n = $urandom_range(0, 3);
            for (int k = 0; k < n; k++) begin
                int t;
                t = $urandom_range(0, 2);
                e[t] = 1'b1;
                fire(3'(1 << t));
                repeat (2) @(negedge clk);
            end
            first = s[2] ? 2 : (s[1] ? 1 : 0);
            rem = (s & ~3'(1 << first)) | e;
            lines[0] = mk_line(first, led, heat);
            n = 1;
            for (int t = 2; t >= 0; t--)
                if (rem[t]) begin
                    lines[n] = mk_line(t, led, heat);
                    n++;
                end
            run_count(400 * n + 200, got, bl);
            chk($sformatf("rnd%0d_done", it), 64'(got), 64'(n));
            chk($sformatf("rnd%0d_bytes", it), 64'(rx_q.size() - base), 64'(8 * n));
            for (int m = 0; m < n; m++)
                chk($sformatf("rnd%0d_line%0d", it, m), rx_line(base + 8 * m), lines[m]);
        end

        // Asynchronous reset in the middle of byte 2.
        led_level = 8'h33; heat_signal = 1'b1;
        base = rx_q.size();
        fire(3'b001);
        wait_bytes(base + 1, ok);
        chk("rst_wait", {63'd0, ok}, 64'd1);
        repeat (15) @(negedge clk);
        #2 n_rst = 1'b0;
        #1 chk("rst_async", {61'd0, tx, busy, msg_done}, 64'd4);
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        sz = rx_q.size();
        got = 0;
        lows = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (msg_done) got++;
            if (tx !== 1'b1) lows++;
        end
        chk("rst_no_done", 64'(got), 64'd0);
        chk("rst_tx_idle", 64'(lows), 64'd0);
        chk("rst_no_bytes", 64'(rx_q.size()), 64'(sz));
        base = rx_q.size();
        fire(3'b100);
        run_count(500, got, bl);
        chk("rst_new_done", 64'(got), 64'd1);
        chk("rst_new_line", rx_line(base), mk_line(2, 8'h33, 1'b1));

        chk("framing", 64'(frame_err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
